mem_port_arbiter: RTL

Shares one single-ported memory bus between the pipeline's instruction-fetch port and its data (MEM-stage) port. Fixed data-over-instruction priority with one-shot anti-starvation for fetch. Returns registered read data with a one-cycle acknowledge, and drives stall flags that the hazard logic ORs into its fetch and memory-stage stalls. Sits between the core datapath and the external SRAM/bus controller.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the data (MEM) stage.
// Define MEM_TIMEOUT_EN to add a bus response timeout that pulses bus_err.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_stall,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} stateT;

  stateT state, stateNext;
  logic  starve;
  logic  iReqEff, dReqEff;
  logic  grantI, grantD, doneOk, doneTimeout, timeoutHit;

  // A requester being acknowledged this cycle has not yet had a chance to
  // present its next request, so it is masked out of arbitration.
  assign iReqEff = i_req & ~i_ack;
  assign dReqEff = d_req & ~d_ack;

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] waitCount;

  assign timeoutHit = (waitCount == TimeoutLimit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCount <= 8'd0;
    end else if (grantI || grantD) begin
      waitCount <= 8'd0;
    end else if (state != IDLE && !mem_ready && !timeoutHit) begin
      waitCount <= waitCount + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= doneTimeout;
    end
  end
`else
  logic [7:0] unusedTimeout;

  assign unusedTimeout = 8'(TIMEOUT_CYCLES);
  assign timeoutHit    = 1'b0;
  assign bus_err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Starve gives fetch precedence once after a data transfer finished while fetch waited.
  always_comb begin
    stateNext   = state;
    grantI      = 1'b0;
    grantD      = 1'b0;
    doneOk      = 1'b0;
    doneTimeout = 1'b0;
    case (state)
      IDLE: begin
        if (starve && iReqEff) begin
          grantI    = 1'b1;
          stateNext = GRANT_I;
        end else if (dReqEff) begin
          grantD    = 1'b1;
          stateNext = GRANT_D;
        end else if (iReqEff) begin
          grantI    = 1'b1;
          stateNext = GRANT_I;
        end
      end
      GRANT_D, GRANT_I: begin
        if (mem_ready) begin
          doneOk    = 1'b1;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          doneTimeout = 1'b1;
          stateNext   = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bus registers, acknowledge pulses and returned read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= 32'h0;
      d_rdata   <= 32'h0;
      starve    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (grantD) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grantI) begin
        mem_req  <= 1'b1;
        mem_we   <= 4'b0000;
        mem_addr <= i_addr;
      end
      if (doneOk || doneTimeout) begin
        mem_req <= 1'b0;
        if (state == GRANT_D) begin
          d_ack   <= 1'b1;
          d_rdata <= doneOk ? mem_rdata : 32'h0;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= doneOk ? mem_rdata : 32'h0;
        end
      end
      if (grantI) begin
        starve <= 1'b0;
      end else if (state == GRANT_D && (doneOk || doneTimeout) && i_req) begin
        starve <= 1'b1;
      end
    end
  end

endmodule
